// File: rtl/addr_port_arb_pkg.sv
// Shared types and helpers for the addr_port_arbiter block.
// Optional grant statistics are enabled with ADDR_PORT_ARB_STATS_EN.
package addr_port_arb_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } arb_state_e;

    localparam int CNT_W = 16;

    function automatic int id_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int rr_idx(input int base, input int k, input int n);
        return (base + k) % n;
    endfunction

endpackage

// File: rtl/addr_port_rsp_tracker.sv
// Read-return tracker: a DEPTH-deep {valid,id} shift pipeline
// whose tail names the requester that owns the current mem_rdata.
module addr_port_rsp_tracker #(
    parameter int DEPTH = 2,
    parameter int IDW   = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_valid,
    input  logic [IDW-1:0] i_id,
    output logic           o_valid,
    output logic [IDW-1:0] o_id,
    output logic           o_empty
);

    logic           r_vld [DEPTH];
    logic [IDW-1:0] r_id  [DEPTH];
    logic           w_any;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_vld[k] <= 1'b0;
                r_id[k]  <= '0;
            end
        end else begin
            r_vld[0] <= i_valid;
            r_id[0]  <= i_id;
            for (int k = 1; k < DEPTH; k++) begin
                r_vld[k] <= r_vld[k-1];
                r_id[k]  <= r_id[k-1];
            end
        end
    end

    always_comb begin
        w_any = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            w_any = w_any | r_vld[k];
        end
    end

    assign o_valid = r_vld[DEPTH-1];
    assign o_id    = r_id[DEPTH-1];
    assign o_empty = ~w_any;

endmodule

// File: rtl/addr_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory among NUM_REQ
// requesters, with flush/drain. Stats: ADDR_PORT_ARB_STATS_EN.
module addr_port_arbiter
    import addr_port_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 2
) (
`ifdef ADDR_PORT_ARB_STATS_EN
    input  logic                          stats_clr,
    output logic [NUM_REQ*CNT_W-1:0]      grant_cnt,
`endif
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          mem_en,
    output logic                          mem_we,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic [DATA_WIDTH-1:0]         mem_wdata,
    input  logic [DATA_WIDTH-1:0]         mem_rdata,
    input  logic                          flush_req,
    output logic                          flush_done
);

    localparam int IDW = id_width(NUM_REQ);

    arb_state_e             r_state;
    arb_state_e             w_state_nxt;
    logic [IDW-1:0]         r_ptr;
    logic [IDW-1:0]         r_id;
    logic [NUM_REQ-1:0]     w_gnt;
    logic [IDW-1:0]         w_gnt_id;
    logic                   w_acc;
    int                     w_j;
    logic                   r_mem_en;
    logic                   r_mem_we;
    logic [ADDR_WIDTH-1:0]  r_mem_addr;
    logic [DATA_WIDTH-1:0]  r_mem_wdata;
    logic                   w_trk_vld;
    logic [IDW-1:0]         w_trk_id;
    logic                   w_trk_empty;

    // First valid requester at or above the pointer, wrapping.
    always_comb begin
        w_gnt    = '0;
        w_gnt_id = '0;
        w_acc    = 1'b0;
        w_j      = 0;
        if (r_state == RUN) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                w_j = rr_idx(int'(r_ptr), k, NUM_REQ);
                if (!w_acc && req_valid[w_j]) begin
                    w_acc      = 1'b1;
                    w_gnt[w_j] = 1'b1;
                    w_gnt_id   = IDW'(w_j);
                end
            end
        end
    end

    assign req_ready = w_gnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr       <= '0;
            r_id        <= '0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_mem_en <= w_acc;
            if (w_acc) begin
                r_ptr       <= IDW'((int'(w_gnt_id) + 1) % NUM_REQ);
                r_id        <= w_gnt_id;
                r_mem_we    <= req_we[w_gnt_id];
                r_mem_addr  <= req_addr[int'(w_gnt_id)*ADDR_WIDTH +: ADDR_WIDTH];
                r_mem_wdata <= req_wdata[int'(w_gnt_id)*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

    addr_port_rsp_tracker #(
        .DEPTH (RD_LATENCY),
        .IDW   (IDW)
    ) u_trk (
        .clk     (clk),
        .rst     (rst),
        .i_valid (r_mem_en & ~r_mem_we),
        .i_id    (r_id),
        .o_valid (w_trk_vld),
        .o_id    (w_trk_id),
        .o_empty (w_trk_empty)
    );

    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_valid[i] = w_trk_vld && (w_trk_id == IDW'(i));
        end
    end

    assign rsp_rdata = mem_rdata;

    always_ff @(posedge clk) begin
        if (rst) r_state <= RUN;
        else     r_state <= w_state_nxt;
    end

    // Drained once no read is in flight and nothing issues this cycle.
    always_comb begin
        w_state_nxt = r_state;
        flush_done  = 1'b0;
        unique case (r_state)
            RUN:   if (flush_req) w_state_nxt = DRAIN;
            DRAIN: if (w_trk_empty && !r_mem_en) w_state_nxt = DONE;
            DONE: begin
                w_state_nxt = RUN;
                flush_done  = 1'b1;
            end
            default: w_state_nxt = RUN;
        endcase
    end

`ifdef ADDR_PORT_ARB_STATS_EN
    logic [CNT_W-1:0] r_cnt [NUM_REQ];

    always_ff @(posedge clk) begin
        if (rst || stats_clr) begin
            for (int i = 0; i < NUM_REQ; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_gnt[i] && (r_cnt[i] != '1)) r_cnt[i] <= r_cnt[i] + 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
        assign grant_cnt[g*CNT_W +: CNT_W] = r_cnt[g];
    end
`endif

endmodule

// File: tb/tb_addr_port_arbiter.sv
// Bench for addr_port_arbiter: directed vector table, hand sequences,
// and randomized traffic against a due-time reference model.
module tb_addr_port_arbiter;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int L  = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    req_we;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            mem_en;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem_rdata;
    logic            flush_req;
    logic            flush_done;
`ifdef ADDR_PORT_ARB_STATS_EN
    logic            stats_clr;
    logic [N*16-1:0] grant_cnt;
`endif

    always #5 clk = ~clk;

    addr_port_arbiter #(
        .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(L)
    ) dut (
`ifdef ADDR_PORT_ARB_STATS_EN
        .stats_clr  (stats_clr),
        .grant_cnt  (grant_cnt),
`endif
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .flush_req  (flush_req),
        .flush_done (flush_done)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        mem_rdata = $urandom();
    endtask

    // Fixed payloads: requester i reads 0x10*(i+1); a2 overrides requester 2.
    task automatic set_payload(input logic [N-1:0] we, input logic [7:0] a2);
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW]  = (i == 2) ? a2 : AW'(8'h10 * (i + 1));
            req_wdata[i*DW +: DW] = (i == 2) ? 32'hDEADBEEF : 32'h1111_0000 + i;
        end
        req_we = we;
    endtask

    typedef struct {
        logic [3:0] vl;
        logic [3:0] we;
        logic [7:0] a2;
        logic       fl;
        logic [3:0] e_rdy;
        logic       e_en;
        logic       e_we;
        logic [7:0] e_addr;
        logic [3:0] e_rsp;
        logic       e_done;
    } vec_t;

    function automatic vec_t v(logic [3:0] vl, logic [3:0] we, logic [7:0] a2,
                               logic fl, logic [3:0] r, logic en, logic ew,
                               logic [7:0] ea, logic [3:0] rs, logic dn);
        vec_t t;
        t.vl = vl; t.we = we; t.a2 = a2; t.fl = fl; t.e_rdy = r;
        t.e_en = en; t.e_we = ew; t.e_addr = ea; t.e_rsp = rs; t.e_done = dn;
        return t;
    endfunction

    // Behavioural reference model
    typedef struct { int due; int id; } rd_t;
    rd_t          pend[$];
    int           m_ptr, m_st, m_cyc;
    bit           m_en, m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wd;

    function automatic int m_grant(input logic [N-1:0] vl);
        if (m_st != 0) return -1;
        for (int k = 0; k < N; k++) begin
            if (vl[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic m_reset();
        m_ptr = 0; m_st = 0; m_en = 0; m_we = 0;
        m_addr = '0; m_wd = '0;
        pend.delete();
    endtask

    task automatic m_check();
        logic [N-1:0] e_rdy, e_rsp;
        int g;
        g = m_grant(req_valid);
        e_rdy = '0;
        if (g >= 0) e_rdy[g] = 1'b1;
        e_rsp = '0;
        foreach (pend[p]) if (pend[p].due == m_cyc) e_rsp[pend[p].id] = 1'b1;
        chk("rnd_ready", req_ready, e_rdy);
        chk("rnd_rsp", rsp_valid, e_rsp);
        if (e_rsp != 0) chk("rnd_rdata", rsp_rdata, mem_rdata);
        chk("rnd_en", mem_en, m_en);
        if (m_en) begin
            chk("rnd_we", mem_we, m_we);
            chk("rnd_addr", mem_addr, m_addr);
            if (m_we) chk("rnd_wdata", mem_wdata, m_wd);
        end
        chk("rnd_done", flush_done, m_st == 2);
    endtask

    task automatic m_step();
        int g;
        bit empty;
        if (rst) begin
            m_reset();
        end else begin
            g = m_grant(req_valid);
            empty = 1'b1;
            foreach (pend[p]) if (pend[p].due >= m_cyc) empty = 1'b0;
            if (m_st == 0 && flush_req) m_st = 1;
            else if (m_st == 1 && empty && !m_en) m_st = 2;
            else if (m_st == 2) m_st = 0;
            if (g >= 0) begin
                m_en = 1; m_we = req_we[g];
                m_addr = req_addr[g*AW +: AW];
                m_wd = req_wdata[g*DW +: DW];
                if (!req_we[g]) pend.push_back('{m_cyc + 1 + L, g});
                m_ptr = (g + 1) % N;
            end else begin
                m_en = 0;
            end
            for (int p = pend.size() - 1; p >= 0; p--) begin
                if (pend[p].due <= m_cyc) pend.delete(p);
            end
        end
        m_cyc++;
    endtask

    vec_t tbl[24];

    initial begin
        tbl[0]  = v(4'hF, 4'h0, 8'h30, 0, 4'h1, 0, 0, 8'h00, 4'h0, 0);
        tbl[1]  = v(4'hE, 4'h0, 8'h30, 0, 4'h2, 1, 0, 8'h10, 4'h0, 0);
        tbl[2]  = v(4'hC, 4'h0, 8'h30, 0, 4'h4, 1, 0, 8'h20, 4'h0, 0);
        tbl[3]  = v(4'h8, 4'h0, 8'h30, 0, 4'h8, 1, 0, 8'h30, 4'h1, 0);
        tbl[4]  = v(4'h0, 4'h0, 8'h30, 0, 4'h0, 1, 0, 8'h40, 4'h2, 0);
        tbl[5]  = v(4'h0, 4'h0, 8'h30, 0, 4'h0, 0, 0, 8'h00, 4'h4, 0);
        tbl[6]  = v(4'h0, 4'h0, 8'h30, 0, 4'h0, 0, 0, 8'h00, 4'h8, 0);
        tbl[7]  = v(4'h4, 4'h4, 8'h55, 0, 4'h4, 0, 0, 8'h00, 4'h0, 0);
        tbl[8]  = v(4'h0, 4'h0, 8'h55, 0, 4'h0, 1, 1, 8'h55, 4'h0, 0);
        tbl[9]  = v(4'h0, 4'h0, 8'h30, 0, 4'h0, 0, 0, 8'h00, 4'h0, 0);
        tbl[10] = v(4'h0, 4'h0, 8'h30, 0, 4'h0, 0, 0, 8'h00, 4'h0, 0);
        tbl[11] = v(4'h9, 4'h0, 8'h30, 0, 4'h8, 0, 0, 8'h00, 4'h0, 0);
        tbl[12] = v(4'h1, 4'h0, 8'h30, 0, 4'h1, 1, 0, 8'h40, 4'h0, 0);
        tbl[13] = v(4'h0, 4'h0, 8'h30, 0, 4'h0, 1, 0, 8'h10, 4'h0, 0);
        tbl[14] = v(4'h0, 4'h0, 8'h30, 0, 4'h0, 0, 0, 8'h00, 4'h8, 0);
        tbl[15] = v(4'h0, 4'h0, 8'h30, 0, 4'h0, 0, 0, 8'h00, 4'h1, 0);
        tbl[16] = v(4'h2, 4'h0, 8'h30, 0, 4'h2, 0, 0, 8'h00, 4'h0, 0);
        tbl[17] = v(4'h0, 4'h0, 8'h30, 1, 4'h0, 1, 0, 8'h20, 4'h0, 0);
        tbl[18] = v(4'h1, 4'h0, 8'h30, 0, 4'h0, 0, 0, 8'h00, 4'h0, 0);
        tbl[19] = v(4'h1, 4'h0, 8'h30, 0, 4'h0, 0, 0, 8'h00, 4'h2, 0);
        tbl[20] = v(4'h1, 4'h0, 8'h30, 0, 4'h0, 0, 0, 8'h00, 4'h0, 0);
        tbl[21] = v(4'h1, 4'h0, 8'h30, 0, 4'h0, 0, 0, 8'h00, 4'h0, 1);
        tbl[22] = v(4'h1, 4'h0, 8'h30, 0, 4'h1, 0, 0, 8'h00, 4'h0, 0);
        tbl[23] = v(4'h0, 4'h0, 8'h30, 0, 4'h0, 1, 0, 8'h10, 4'h0, 0);

        rst = 1'b1; req_valid = '0; flush_req = 1'b0; mem_rdata = '0;
        set_payload('0, 8'h30);
`ifdef ADDR_PORT_ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        tick(); tick();
        #2;
        chk("rst_ready", req_ready, 0);
        chk("rst_rsp", rsp_valid, 0);
        chk("rst_en", mem_en, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_done", flush_done, 0);
        rst = 1'b0;

        for (int i = 0; i < 24; i++) begin
            req_valid = tbl[i].vl;
            flush_req = tbl[i].fl;
            set_payload(tbl[i].we, tbl[i].a2);
            #2;
            chk($sformatf("vec%0d_ready", i), req_ready, tbl[i].e_rdy);
            chk($sformatf("vec%0d_en", i), mem_en, tbl[i].e_en);
            if (tbl[i].e_en) begin
                chk($sformatf("vec%0d_we", i), mem_we, tbl[i].e_we);
                chk($sformatf("vec%0d_addr", i), mem_addr, tbl[i].e_addr);
                if (tbl[i].e_we)
                    chk($sformatf("vec%0d_wdata", i), mem_wdata, 32'hDEADBEEF);
            end
            chk($sformatf("vec%0d_rsp", i), rsp_valid, tbl[i].e_rsp);
            if (tbl[i].e_rsp != 0)
                chk($sformatf("vec%0d_rdata", i), rsp_rdata, mem_rdata);
            chk($sformatf("vec%0d_done", i), flush_done, tbl[i].e_done);
            tick();
        end
        flush_req = 1'b0;

        // Reset one cycle after a read accept discards that read.
        set_payload('0, 8'h30);
        req_valid = 4'b0010;
        #2 chk("rsq_ready", req_ready, 4'b0010);
        tick();
        req_valid = '0; rst = 1'b1;
        tick();
        rst = 1'b0;
        #2;
        chk("rsq_en", mem_en, 0);
        chk("rsq_addr", mem_addr, 0);
        chk("rsq_wdata", mem_wdata, 0);
        chk("rsq_we", mem_we, 0);
        chk("rsq_ready0", req_ready, 0);
        chk("rsq_done", flush_done, 0);
        for (int i = 0; i < 4; i++) begin
            #1 chk($sformatf("rsq_rsp%0d", i), rsp_valid, 0);
            tick();
        end
        req_valid = 4'b0110;
        #2 chk("rsq_ptr0", req_ready, 4'b0010);
        tick();
        req_valid = '0;

        // Randomized traffic against the model.
        rst = 1'b1;
        tick();
        m_reset();
        m_cyc = 0;
        rst = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            flush_req = ($urandom_range(0, 39) == 0);
            req_valid = N'($urandom());
            req_we = N'($urandom());
            for (int i = 0; i < N; i++) begin
                req_addr[i*AW +: AW] = AW'($urandom());
                req_wdata[i*DW +: DW] = $urandom();
            end
            #2;
            m_check();
            m_step();
            tick();
        end
        rst = 1'b0; flush_req = 1'b0; req_valid = '0;

`ifdef ADDR_PORT_ARB_STATS_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req_valid = 4'b0010;
        repeat (5) tick();
        req_valid = '0;
        #2 chk("cnt1_five", grant_cnt[16 +: 16], 16'd5);
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        #2 chk("cnt1_clr", grant_cnt[16 +: 16], 16'd0);
        req_valid = 4'b0010; stats_clr = 1'b1;
        tick();
        req_valid = '0; stats_clr = 1'b0;
        #2 chk("cnt1_clrwin", grant_cnt[16 +: 16], 16'd0);
        req_valid = 4'b0001;
        repeat (65538) tick();
        req_valid = '0;
        #2 chk("cnt0_sat", grant_cnt[0 +: 16], 16'hFFFF);
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
